// File: rtl/monolith_pkg.sv
// Shared Mersenne-31 definitions for the Monolith Bricks datapath.
// Combinational helpers only; no clocked state lives here.
// Used by the Bricks inverse and its subtractor.
package monolith_pkg;

  // Field modulus p = 2^31 - 1.
  localparam logic [30:0] M31_P = 31'h7FFF_FFFF;

  // Default state geometry for benches and neighbouring blocks.
  localparam int M31_STATE_SIZE = 16;

  typedef logic [30:0] m31_t;
  typedef m31_t m31_state_t [M31_STATE_SIZE];

  // FSM encoding. STEP reuses the SQ code in the single-cycle build.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SQ   = 2'd1,
    ST_SUB  = 2'd2,
    ST_DONE = 2'd3
  } fsm_t;

  localparam fsm_t ST_STEP = ST_SQ;

  // 62-bit to canonical 31-bit reduction. 2^31 == 1 (mod p), so the high
  // part folds onto the low part. Two folds bring any value below 2^31 + 1.
  // One conditional subtract then makes it canonical.
  function automatic m31_t m31_reduce(input logic [61:0] v);
    logic [31:0] s1;
    logic [31:0] s2;
    s1 = {1'b0, v[30:0]} + {1'b0, v[61:31]};
    s2 = {1'b0, s1[30:0]} + {31'd0, s1[31]};
    if (s2 >= {1'b0, M31_P}) begin
      s2 = s2 - {1'b0, M31_P};
    end
    return s2[30:0];
  endfunction

  // Map the one non-canonical 31-bit code (p itself) onto 0.
  function automatic m31_t m31_canon(input m31_t v);
    return (v == M31_P) ? 31'd0 : v;
  endfunction

endpackage

// File: rtl/m31_subtractor.sv
// Canonical (a - b) mod p for canonical a, b.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module m31_subtractor
  import monolith_pkg::*;
(
  input  logic [30:0] a_i,
  input  logic [30:0] b_i,
  output logic [30:0] diff_o
);

  logic [31:0] raw_diff;
  logic [31:0] wrapped;
  logic        borrow;

  // A borrow means a < b. Adding p back lands the result in [1, p-1].
  always_comb begin
    raw_diff = {1'b0, a_i} - {1'b0, b_i};
    borrow   = (a_i < b_i);
    wrapped  = raw_diff + {1'b0, M31_P};
    diff_o   = borrow ? wrapped[30:0] : raw_diff[30:0];
  end

endmodule

// File: rtl/monolith_bricks_inv.sv
// Serial inverse of Monolith Bricks over M31: x[i] = y[i] - x[i-1]^2 mod p.
// Latency: 2*(STATE_SIZE-1) edges accept->out_valid; STATE_SIZE-1 with MONOLITH_BRICKS_INV_FAST_EN.
// Backpressure: valid/ready both sides; result held in DONE until out_ready, input taken only in IDLE.
module monolith_bricks_inv
  import monolith_pkg::*;
#(
  parameter int WORD_WIDTH = 31,
  parameter int STATE_SIZE = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] state_in  [STATE_SIZE],
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] state_out [STATE_SIZE],
  output logic                  busy
);

  localparam int IDX_W = (STATE_SIZE > 2) ? $clog2(STATE_SIZE) : 1;
  localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(STATE_SIZE - 1);

  fsm_t             state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] prev_idx;
  logic             last_idx;

  // Working array: holds y on accept and is overwritten in place with x.
  m31_t w_q [STATE_SIZE];
  m31_t w_d [STATE_SIZE];

  logic [61:0] sq_prod;
  m31_t        sq_val;
  m31_t        sub_b;
  m31_t        sub_res;

`ifndef MONOLITH_BRICKS_INV_FAST_EN
  // Registered square; splits the multiplier/reduce from the subtract path.
  m31_t sq_q, sq_d;
`endif

  assign prev_idx = idx_q - IDX_W'(1);
  assign last_idx = (idx_q == IDX_LAST);

  // Shared squarer on the previously recovered element.
  always_comb begin
    sq_prod = 62'(w_q[prev_idx]) * 62'(w_q[prev_idx]);
    sq_val  = m31_reduce(sq_prod);
  end

`ifdef MONOLITH_BRICKS_INV_FAST_EN
  assign sub_b = sq_val;
`else
  assign sub_b = sq_q;
`endif

  m31_subtractor u_sub (
    .a_i    (w_q[idx_q]),
    .b_i    (sub_b),
    .diff_o (sub_res)
  );

  // Next-state logic for FSM, index and working array.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    w_d     = w_q;
`ifndef MONOLITH_BRICKS_INV_FAST_EN
    sq_d    = sq_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          for (int i = 0; i < STATE_SIZE; i++) begin
            w_d[i] = m31_canon(m31_t'(state_in[i]));
          end
          idx_d   = IDX_FIRST;
`ifdef MONOLITH_BRICKS_INV_FAST_EN
          state_d = ST_STEP;
`else
          state_d = ST_SQ;
`endif
        end
      end
`ifdef MONOLITH_BRICKS_INV_FAST_EN
      ST_STEP: begin
        w_d[idx_q] = sub_res;
        if (last_idx) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
        end
      end
`else
      ST_SQ: begin
        sq_d    = sq_val;
        state_d = ST_SUB;
      end
      ST_SUB: begin
        w_d[idx_q] = sub_res;
        if (last_idx) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_SQ;
        end
      end
`endif
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; synchronous reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      for (int i = 0; i < STATE_SIZE; i++) begin
        w_q[i] <= '0;
      end
`ifndef MONOLITH_BRICKS_INV_FAST_EN
      sq_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      w_q     <= w_d;
`ifndef MONOLITH_BRICKS_INV_FAST_EN
      sq_q    <= sq_d;
`endif
    end
  end

  // Handshake outputs are pure state decodes.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q != ST_IDLE);
    for (int i = 0; i < STATE_SIZE; i++) begin
      state_out[i] = WORD_WIDTH'(w_q[i]);
    end
  end

endmodule

// File: tb/tb_monolith_bricks_inv.sv
// Directed bench for the Monolith Bricks inverse.
// Covers reset, zeros, round trip, wrap-around, non-canonical input,
// output backpressure and mid-operation reset.
module tb_monolith_bricks_inv;

  localparam int N = 16;
`ifdef MONOLITH_BRICKS_INV_FAST_EN
  localparam int LAT = 15;
`else
  localparam int LAT = 30;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic        busy;
  logic [30:0] state_in  [N];
  logic [30:0] state_out [N];
  logic [30:0] vexp      [N];
  int          ncmp;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  monolith_bricks_inv #(
    .WORD_WIDTH (31),
    .STATE_SIZE (N)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_in  (state_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_op();
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    chk("in_ready_while_busy", {31'd0, in_ready}, 32'd0);
  endtask

  task automatic wait_out();
    int lat;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(LAT));
  endtask

  task automatic check_result();
    for (int i = 0; i < ncmp; i++) begin
      chk($sformatf("out[%0d]", i), {1'b0, state_out[i]}, {1'b0, vexp[i]});
    end
    chk("out_valid_done", {31'd0, out_valid}, 32'd1);
    chk("in_ready_done", {31'd0, in_ready}, 32'd0);
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
    chk("out_valid_after_hs", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic load_roundtrip();
    state_in = '{1, 3, 7, 13, 21, 31, 43, 57, 73, 91, 111, 133, 157, 183, 211, 241};
    for (int i = 0; i < N; i++) vexp[i] = 31'(i + 1);
    ncmp = N;
  endtask

  initial begin
    for (int i = 0; i < N; i++) state_in[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_out0", {1'b0, state_out[0]}, 32'd0);
    chk("rst_out15", {1'b0, state_out[15]}, 32'd0);

    // Zeros with out_ready held high: result shows for one cycle only.
    for (int i = 0; i < N; i++) begin
      state_in[i] = '0;
      vexp[i] = '0;
    end
    ncmp = N;
    out_ready = 1'b1;
    start_op();
    wait_out();
    check_result();
    @(posedge clk);
    #1;
    chk("zeros_in_ready_next", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b0;

    // Round trip of 1..16.
    load_roundtrip();
    start_op();
    wait_out();
    check_result();
    release_out();

    // Wrap-around below zero.
    for (int i = 0; i < N; i++) state_in[i] = '0;
    state_in[0] = 31'd2;
    vexp[0] = 31'd2;
    vexp[1] = 31'd2147483643;
    vexp[2] = 31'd2147483631;
    vexp[3] = 31'd2147483391;
    vexp[4] = 31'd2147418111;
    vexp[5] = 31'd2147483645;
    ncmp = 6;
    start_op();
    wait_out();
    check_result();
    release_out();

    // Non-canonical p is taken as zero.
    for (int i = 0; i < N; i++) begin
      state_in[i] = '0;
      vexp[i] = '0;
    end
    state_in[0] = 31'h7FFF_FFFF;
    ncmp = N;
    start_op();
    wait_out();
    check_result();

    // Backpressure: result stays put for five stalled cycles.
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_out0", {1'b0, state_out[0]}, 32'd0);
    end
    release_out();

    // Accept in the cycle right after the handshake.
    load_roundtrip();
    start_op();
    wait_out();
    check_result();
    release_out();

    // Mid-operation reset, then a clean run.
    load_roundtrip();
    start_op();
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("midrst_out[%0d]", i), {1'b0, state_out[i]}, 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    start_op();
    wait_out();
    check_result();
    release_out();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
